// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command-frame decoder: FSM encodings,
// abort cause codes and the default frame start marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Clearable inter-byte idle counter. terminal_count is high while the count
// sits at TIMEOUT_CLKS-1; the counter saturates there until cleared.
module uart_frame_timeout #(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic clear,
  output logic terminal_count
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TC_VALUE = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != TC_VALUE) begin
      count <= count + CW'(1);
    end
  end

  assign terminal_count = (count == TC_VALUE);

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC,CMD,LEN,payload[LEN],CHK frames from UART byte strobes and
// commits good frames atomically. Define UART_FRAME_CHECKSUM_EN to keep CHK.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 4,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  output logic                 o_Frame_Valid,
  output logic [7:0]           o_Cmd,
  output logic [3:0]           o_Len,
  output logic [8*MAX_LEN-1:0] o_Payload,
  output logic                 o_Frame_Err,
  output logic [1:0]           o_Err_Code,
  output logic                 o_Busy,
  output state_t               o_Dbg_State
);

  // Input handshake: i_Rx_DV is a one-cycle strobe qualifying i_Rx_Byte; there
  // is no back-pressure, so every strobe is consumed on the cycle it is high.
  state_t               state_q, state_d;
  logic [7:0]           cmd_w, cmd_d;
  logic [3:0]           len_w, len_d;
  logic [8*MAX_LEN-1:0] pay_w, pay_d;
  logic [3:0]           idx_q, idx_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif
  logic                 commit, abort;
  logic [1:0]           abort_code;
  logic                 timeout_tc;

  uart_frame_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .i_Clock        (i_Clock),
    .i_Reset_n      (i_Reset_n),
    .clear          (i_Rx_DV | (state_q == S_SYNC)),
    .terminal_count (timeout_tc)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= S_SYNC;
    else            state_q <= state_d;
  end

  // The *_d working values include the byte arriving this cycle, so a commit
  // on the final byte (no-checksum build) already sees it.
  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_LEN;
    cmd_d      = cmd_w;
    len_d      = len_w;
    pay_d      = pay_w;
    idx_d      = idx_q;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    if (i_Rx_DV) begin
      case (state_q)
        S_SYNC: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_CMD;
            pay_d   = '0;
            idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_d   = '0;
`endif
          end
        end
        S_CMD: begin
          cmd_d   = i_Rx_Byte;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d   = chk_q ^ i_Rx_Byte;
`endif
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = i_Rx_Byte[3:0];
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ i_Rx_Byte;
`endif
          if (i_Rx_Byte > 8'(MAX_LEN)) begin
            abort      = 1'b1;
            abort_code = ERR_LEN;
            state_d    = S_SYNC;
          end else if (i_Rx_Byte == 8'd0) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            commit  = 1'b1;
            state_d = S_SYNC;
`endif
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) pay_d[i*8 +: 8] = i_Rx_Byte;
          end
          idx_d = idx_q + 4'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ i_Rx_Byte;
`endif
          if (idx_q == len_w - 4'd1) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            commit  = 1'b1;
            state_d = S_SYNC;
`endif
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK: begin
          if (i_Rx_Byte == chk_q) begin
            commit = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CHK;
          end
          state_d = S_SYNC;
        end
`endif
        default: state_d = S_SYNC;
      endcase
    end else if ((state_q != S_SYNC) && timeout_tc) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
      state_d    = S_SYNC;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cmd_w <= '0;
      len_w <= '0;
      pay_w <= '0;
      idx_q <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      cmd_w <= cmd_d;
      len_w <= len_d;
      pay_w <= pay_d;
      idx_q <= idx_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end

  // Committed outputs only move on a good frame; aborts touch only the error pair.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Frame_Valid <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Err_Code    <= ERR_NONE;
      o_Cmd         <= '0;
      o_Len         <= '0;
      o_Payload     <= '0;
      o_Busy        <= 1'b0;
    end else begin
      o_Frame_Valid <= commit;
      o_Frame_Err   <= abort;
      o_Busy        <= (state_d != S_SYNC);
      if (abort) o_Err_Code <= abort_code;
      if (commit) begin
        o_Cmd     <= cmd_d;
        o_Len     <= len_d;
        o_Payload <= pay_d;
      end
    end
  end

  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; expected pulses go to a queue that a
// negedge monitor pops. Works with UART_FRAME_CHECKSUM_EN defined or not.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  localparam int MAX_LEN = 4;
  localparam int TO_CLKS = 16;
  localparam int W       = 47; // {kind, code[1:0], cmd[7:0], len[3:0], payload[31:0]}

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [3:0]  len;
  logic [31:0] payload;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  state_t      dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl_cmd;
  logic [3:0]  mdl_len;
  logic [31:0] mdl_pay;

  uart_frame_decoder #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TO_CLKS),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Frame_Valid (frame_valid),
    .o_Cmd         (cmd),
    .o_Len         (len),
    .o_Payload     (payload),
    .o_Frame_Err   (frame_err),
    .o_Err_Code    (err_code),
    .o_Busy        (busy),
    .o_Dbg_State   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: each byte is a one-cycle strobe followed by one idle cycle.
  task automatic send_byte(input logic [7:0] b, input bit pulse_due);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    if (pulse_due) check("pulse_latency", {47'd0, frame_valid | frame_err}, 48'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_ok(input logic [7:0] c, input logic [3:0] l, input logic [31:0] p);
    exp_q.push_back({1'b1, 2'b00, c, l, p});
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_q.push_back({1'b0, code, 8'h00, 4'h0, 32'h0});
  endtask

  // Sends a complete frame whose payload bytes come from p; chk_flip corrupts CHK.
  task automatic send_frame(input logic [7:0] c, input logic [3:0] l, input logic [31:0] p,
                            input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = c ^ {4'h0, l};
    for (int i = 0; i < int'(l); i++) chk ^= p[i*8 +: 8];
    send_byte(8'hA5, 1'b0);
    send_byte(c, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte({4'h0, l}, 1'b0);
    for (int i = 0; i < int'(l); i++) send_byte(p[i*8 +: 8], 1'b0);
    send_byte(chk ^ chk_flip, 1'b1);
`else
    send_byte({4'h0, l}, l == 4'd0);
    for (int i = 0; i < int'(l); i++) send_byte(p[i*8 +: 8], i == int'(l) - 1);
`endif
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      mdl_cmd = '0;
      mdl_len = '0;
      mdl_pay = '0;
    end else begin
      if (frame_valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL valid_and_err_together actual=11 required=not both");
      end
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual valid=%0b err=%0b code=%0b required=no pulse",
                   frame_valid, frame_err, err_code);
        end else begin
          e = exp_q.pop_front();
          if (e[46]) begin
            check("commit", {1'b0, frame_valid, 2'b00, cmd, len, payload},
                  {1'b0, 1'b1, 2'b00, e[43:0]});
            mdl_cmd = e[43:36];
            mdl_len = e[35:32];
            mdl_pay = e[31:0];
          end else begin
            check("abort_code", {45'd0, frame_err, err_code}, {45'd0, 1'b1, e[45:44]});
            check("abort_holds_outputs", {4'd0, cmd, len, payload},
                  {4'd0, mdl_cmd, mdl_len, mdl_pay});
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {frame_valid, frame_err, err_code, cmd, len, payload}, 48'd0);
    check("reset_busy_state", {44'd0, busy, dbg_state}, 48'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame A5 10 02 12 34 (34)
    push_ok(8'h10, 4'd2, 32'h0000_3412);
    send_frame(8'h10, 4'd2, 32'h0000_3412, 8'h00);
    check("busy_after_commit", {47'd0, busy}, 48'd0);

`ifdef UART_FRAME_CHECKSUM_EN
    // Bad checksum: CHK sent as 35
    push_err(ERR_CHK);
    send_frame(8'h10, 4'd2, 32'h0000_3412, 8'h01);
`endif

    // Oversize LEN 05 > MAX_LEN
    push_err(ERR_LEN);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h05, 1'b1);

    // Zero-length frame straight after an abort
    push_ok(8'h20, 4'd0, 32'h0);
    send_frame(8'h20, 4'd0, 32'h0, 8'h00);

    // Full MAX_LEN payload, then a one-byte frame whose data equals SYNC
    push_ok(8'h44, 4'd4, 32'hEFBE_ADDE);
    send_frame(8'h44, 4'd4, 32'hEFBE_ADDE, 8'h00);
    push_ok(8'h55, 4'd1, 32'h0000_00A5);
    send_frame(8'h55, 4'd1, 32'h0000_00A5, 8'h00);

    // Timeout: A5 10 then idle; abort lands exactly TO_CLKS edges after the CMD DV
    push_err(ERR_TIMEOUT);
    send_byte(8'hA5, 1'b0);
    check("busy_mid_frame", {47'd0, busy}, 48'd1);
    send_byte(8'h10, 1'b0);
    idle(TO_CLKS - 2);
    check("no_timeout_before_tc", {47'd0, frame_err}, 48'd0);
    idle(1);
    check("timeout_pulse_time", {47'd0, frame_err}, 48'd1);
    idle(1);
    check("sync_after_timeout", {44'd0, busy, dbg_state}, 48'd0);
    idle(2);

    // DV on the terminal-count cycle wins
    push_ok(8'h10, 4'd1, 32'h0000_00AB);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    idle(TO_CLKS - 2);
    send_byte(8'h01, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hAB, 1'b0);
    send_byte(8'hBA, 1'b1);
`else
    send_byte(8'hAB, 1'b1);
`endif

    // Noise bytes, partial frame, then reset before the final byte
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h01, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hAB, 1'b0);
`endif
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {frame_valid, frame_err, err_code, cmd, len, payload}, 48'd0);
    check("midframe_reset_busy", {44'd0, busy, dbg_state}, 48'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    push_ok(8'h33, 4'd3, 32'h0003_0201);
    send_frame(8'h33, 4'd3, 32'h0003_0201, 8'h00);

    idle(TO_CLKS + 4);
    check("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
